// File: rtl/inst_encoder.sv
// MIPS instruction encoder: turns one operation request into one (or, for LI, up to three) 32-bit words.
// Optional LI pseudo-op expansion is built only when INST_ENCODER_LI_EXPAND_EN is defined.
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err_unsupported,
    output logic [1:0]  dbg_state
);

    // Handshake: a beat moves when valid && ready on the same rising edge; a
    // producer holds its payload steady while valid is high and ready is low.

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LI_SLL = 2'd1;
    localparam logic [1:0] LI_ORI = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_JR   = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_ORI  = 5'd10;
    localparam logic [4:0] OP_SLTI = 5'd11;
    localparam logic [4:0] OP_LW   = 5'd12;
    localparam logic [4:0] OP_SW   = 5'd13;
    localparam logic [4:0] OP_BEQ  = 5'd14;
    localparam logic [4:0] OP_BNE  = 5'd15;
    localparam logic [4:0] OP_J    = 5'd16;
    localparam logic [4:0] OP_JAL  = 5'd17;
`ifdef INST_ENCODER_LI_EXPAND_EN
    localparam logic [4:0] OP_LI   = 5'd18;
`endif

    logic [1:0]  state;
    logic        load;
    logic        accept;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        enc_multi;

    // The output register can take a new word when it is empty or being drained.
    assign load      = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && load;
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    always_comb begin
        enc_word  = '0;
        enc_ok    = 1'b1;
        enc_multi = 1'b0;
        case (in_op)
            OP_ADD:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            OP_SUB:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            OP_AND:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            OP_OR:   enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            OP_SLT:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
            OP_SLL:  enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, 6'h00};
            OP_SRL:  enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, 6'h02};
            OP_JR:   enc_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
            OP_ADDI: enc_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
            OP_ANDI: enc_word = {6'h0C, in_rs, in_rt, in_imm[15:0]};
            OP_ORI:  enc_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
            OP_SLTI: enc_word = {6'h0A, in_rs, in_rt, in_imm[15:0]};
            OP_LW:   enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
            OP_SW:   enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
            OP_BEQ:  enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
            OP_BNE:  enc_word = {6'h05, in_rs, in_rt, in_imm[15:0]};
            OP_J:    enc_word = {6'h02, in_imm[25:0]};
            OP_JAL:  enc_word = {6'h03, in_imm[25:0]};
`ifdef INST_ENCODER_LI_EXPAND_EN
            OP_LI: begin
                if (in_imm[31:16] == 16'h0000) begin
                    enc_word = {6'h0D, 5'd0, in_rt, in_imm[15:0]};
                end else begin
                    enc_word  = {6'h0D, 5'd0, in_rt, in_imm[31:16]};
                    enc_multi = 1'b1;
                end
            end
`endif
            default: enc_ok = 1'b0;
        endcase
    end

`ifdef INST_ENCODER_LI_EXPAND_EN
    logic [4:0]  li_rt;
    logic [15:0] li_imm_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            li_rt     <= '0;
            li_imm_lo <= '0;
        end else if (load) begin
            case (state)
                LI_SLL:  state <= LI_ORI;
                LI_ORI:  state <= IDLE;
                default: begin
                    // Only the register and low half are needed once the first word is out.
                    if (accept && enc_ok && enc_multi) begin
                        state     <= LI_SLL;
                        li_rt     <= in_rt;
                        li_imm_lo <= in_imm[15:0];
                    end
                end
            endcase
        end
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:26];
    assign state         = IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            out_inst        <= '0;
            err_unsupported <= 1'b0;
        end else begin
            err_unsupported <= accept && !enc_ok;
            if (load) begin
                out_valid <= 1'b0;
                case (state)
`ifdef INST_ENCODER_LI_EXPAND_EN
                    LI_SLL: begin
                        out_valid <= 1'b1;
                        out_inst  <= {6'h00, 5'd0, li_rt, li_rt, 5'd16, 6'h00};
                        out_last  <= 1'b0;
                    end
                    LI_ORI: begin
                        out_valid <= 1'b1;
                        out_inst  <= {6'h0D, li_rt, li_rt, li_imm_lo};
                        out_last  <= 1'b1;
                    end
`endif
                    default: begin
                        if (accept && enc_ok) begin
                            out_valid <= 1'b1;
                            out_inst  <= enc_word;
                            out_last  <= !enc_multi;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table, backpressure, unsupported-op, LI expansion and reset-abort sequences.
// Expectations for op 18 follow whether INST_ENCODER_LI_EXPAND_EN is defined.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        err_unsupported;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    typedef struct {
        logic [4:0]  op, rs, rt, rd, sh;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    inst_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_last(out_last),
        .err_unsupported(err_unsupported), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // scoreboard: pop on every output transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_inst, 32'hDEAD_BEEF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("out_inst", out_inst, e[31:0]);
                check("out_last", {31'd0, out_last}, {31'd0, e[32]});
            end
        end
    end

    task automatic set_vec(input int i, input logic [4:0] op, rs, rt, rd, sh,
                           input logic [31:0] imm, input logic [31:0] exp);
        vecs[i].op = op; vecs[i].rs = rs; vecs[i].rt = rt; vecs[i].rd = rd;
        vecs[i].sh = sh; vecs[i].imm = imm; vecs[i].exp = exp;
    endtask

    // driver: present a beat, wait (bounded) for in_ready, return just after the accepting edge
    task automatic send(input logic [4:0] op, rs, rt, rd, sh, input logic [31:0] imm,
                        output int waits);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
        in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        set_vec(0,  5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  32'h0,         32'h00221820);
        set_vec(1,  5'd1,  5'd4,  5'd5,  5'd6,  5'd7,  32'h0,         32'h00853022);
        set_vec(2,  5'd2,  5'd31, 5'd31, 5'd31, 5'd0,  32'h0,         32'h03FFF824);
        set_vec(3,  5'd3,  5'd1,  5'd0,  5'd2,  5'd0,  32'h0,         32'h00201025);
        set_vec(4,  5'd4,  5'd2,  5'd3,  5'd4,  5'd0,  32'h0,         32'h0043202A);
        set_vec(5,  5'd5,  5'd0,  5'd8,  5'd8,  5'd16, 32'h0,         32'h00084400);
        set_vec(6,  5'd6,  5'd0,  5'd2,  5'd3,  5'd31, 32'h0,         32'h00021FC2);
        set_vec(7,  5'd7,  5'd31, 5'd5,  5'd6,  5'd3,  32'h0,         32'h03E00008);
        set_vec(8,  5'd8,  5'd1,  5'd2,  5'd0,  5'd0,  32'hABCD_FFFF,  32'h2022FFFF);
        set_vec(9,  5'd9,  5'd3,  5'd4,  5'd0,  5'd0,  32'h0000_00FF,  32'h306400FF);
        set_vec(10, 5'd10, 5'd0,  5'd7,  5'd0,  5'd0,  32'h0000_1234,  32'h34071234);
        set_vec(11, 5'd11, 5'd5,  5'd6,  5'd0,  5'd0,  32'h0000_8000,  32'h28A68000);
        set_vec(12, 5'd12, 5'd29, 5'd5,  5'd0,  5'd0,  32'h0000_0004,  32'h8FA50004);
        set_vec(13, 5'd13, 5'd29, 5'd31, 5'd0,  5'd0,  32'h0000_FFFC,  32'hAFBFFFFC);
        set_vec(14, 5'd14, 5'd1,  5'd2,  5'd0,  5'd0,  32'h0000_0003,  32'h10220003);
        set_vec(15, 5'd15, 5'd3,  5'd0,  5'd0,  5'd0,  32'h0000_FFFF,  32'h1460FFFF);
        set_vec(16, 5'd16, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0000_0100,  32'h08000100);
        set_vec(17, 5'd17, 5'd0,  5'd0,  5'd0,  5'd0,  32'hFFFF_FFFF,  32'h0FFFFFFF);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_err", {31'd0, err_unsupported}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // table: back-to-back beats with the consumer always ready
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back({1'b1, vecs[i].exp});
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, w);
            if (i > 0) check("no_bubble", w, 0);
        end
        @(posedge clk); #1;

        // backpressure: word must hold while the consumer stalls
        out_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h00221820});
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, w);
        in_op = 5'd3; in_rs = 5'd9;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_inst", out_inst, 32'h00221820);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1;

        // unsupported op
        send(5'd25, $urandom_range(0, 31), $urandom_range(0, 31), 5'd0, 5'd0, $urandom, w);
        @(negedge clk);
        check("unsup_err", {31'd0, err_unsupported}, 32'd1);
        check("unsup_no_word", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("unsup_err_pulse", {31'd0, err_unsupported}, 32'd0);
        @(posedge clk); #1;

`ifdef INST_ENCODER_LI_EXPAND_EN
        // LI three-word expansion; inputs scrambled after acceptance
        exp_q.push_back({1'b0, 32'h34081234});
        exp_q.push_back({1'b0, 32'h00084400});
        exp_q.push_back({1'b1, 32'h35085678});
        send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, w);
        in_rt = 5'd3; in_imm = 32'hFFFF_FFFF; in_op = 5'd0;
        @(negedge clk);
        check("li_ready_0", {31'd0, in_ready}, 32'd0);
        check("li_state_sll", {30'd0, dbg_state}, 32'd1);
        @(negedge clk);
        check("li_ready_1", {31'd0, in_ready}, 32'd0);
        check("li_state_ori", {30'd0, dbg_state}, 32'd2);
        @(negedge clk);
        check("li_ready_done", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // LI with zero upper half: single word
        exp_q.push_back({1'b1, 32'h34085678});
        send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h00005678, w);
        @(negedge clk);
        check("li_short_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;

        // reset after the first LI word: remaining words discarded
        exp_q.push_back({1'b0, 32'h34081234});
        send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("abort_quiet", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
`else
        // LI is unsupported in this build
        send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, w);
        @(negedge clk);
        check("li_off_err", {31'd0, err_unsupported}, 32'd1);
        check("li_off_no_word", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        send(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 32'h00005678, w);
        @(negedge clk);
        check("li_off_err2", {31'd0, err_unsupported}, 32'd1);
        check("li_off_no_word2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("li_off_err_pulse", {31'd0, err_unsupported}, 32'd0);
        @(posedge clk); #1;
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
